sfifo_asym_gen: RTL and testbench

SFIFO_ASYM_GEN -- requirements
Module: sfifo_asym_gen

---
 rtl/sfifo_asym_gen_if.sv | 31 +++
 rtl/sfifo_asym_gen.sv | 116 +++++++++++
 tb/tb_sfifo_asym_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_asym_gen_if.sv
// Handshake and status bundle for the asymmetric-width synchronous FIFO.
// Signal names follow the FIFO datasheet so existing integrations map one-to-one.
interface sfifo_asym_gen_if #(
  parameter int unsigned WR_DATA_WIDTH = 9,
  parameter int unsigned RD_DATA_WIDTH = 36
);
  logic                     PUSH;
  logic                     POP;
  logic [WR_DATA_WIDTH-1:0] DIN;
  logic [RD_DATA_WIDTH-1:0] DOUT;
  logic                     Full;
  logic                     Almost_Full;
  logic                     Full_Watermark;
  logic                     Overrun_Error;
  logic                     Empty;
  logic                     Almost_Empty;
  logic                     Empty_Watermark;
  logic                     Underrun_Error;

  modport master (
    output PUSH, POP, DIN,
    input  DOUT, Full, Almost_Full, Full_Watermark, Overrun_Error,
    input  Empty, Almost_Empty, Empty_Watermark, Underrun_Error
  );

  modport slave (
    input  PUSH, POP, DIN,
    output DOUT, Full, Almost_Full, Full_Watermark, Overrun_Error,
    output Empty, Almost_Empty, Empty_Watermark, Underrun_Error
  );
endinterface

// File: rtl/sfifo_asym_gen.sv
// Synchronous FIFO with different write/read word widths (ratio 1, 2, 4 or inverse).
// Storage and occupancy are kept in narrow units; all flags are registered.
module sfifo_asym_gen #(
  parameter int unsigned WR_DATA_WIDTH = 9,
  parameter int unsigned RD_DATA_WIDTH = 36,
  parameter int unsigned DEPTH_UNITS   = 4096,
  parameter logic [11:0] UPAE_DBITS    = 12'd10,
  parameter logic [11:0] UPAF_DBITS    = 12'd10,
  parameter int unsigned FWFT          = 0
) (
  input logic             CLK,
  input logic             Sync_Flush,
  sfifo_asym_gen_if.slave bus_io
);

  localparam int unsigned N  = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int unsigned WU = WR_DATA_WIDTH / N;
  localparam int unsigned RU = RD_DATA_WIDTH / N;
  localparam int unsigned AW = $clog2(DEPTH_UNITS);
  localparam int unsigned CW = AW + 1;
  localparam bit          Fwft = (FWFT != 0);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH_UNITS);
  localparam logic [CW-1:0] WuC    = CW'(WU);
  localparam logic [CW-1:0] RuC    = CW'(RU);

  logic [N-1:0]             mem_q [DEPTH_UNITS];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [RD_DATA_WIDTH-1:0] dout_q;
  logic [RD_DATA_WIDTH-1:0] rd_word;
  logic [5:0]               flags_q;
  logic                     ovr_q, udr_q;
  logic                     full_q, empty_q;
  logic                     push_ok, pop_ok;

  // {Full, Almost_Full, Full_Watermark, Empty, Almost_Empty, Empty_Watermark}
  function automatic logic [5:0] flags_of(input logic [CW-1:0] c);
    logic [CW-1:0] free_w;
    logic [CW-1:0] avail_r;
    free_w  = (DepthC - c) / WuC;
    avail_r = c / RuC;
    return {free_w == '0, free_w == CW'(1), 32'(free_w) <= 32'(UPAF_DBITS),
            avail_r == '0, avail_r == CW'(1), 32'(avail_r) <= 32'(UPAE_DBITS)};
  endfunction

  assign full_q  = flags_q[5];
  assign empty_q = flags_q[2];
  assign push_ok = bus_io.PUSH & ~full_q;
  assign pop_ok  = bus_io.POP & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(WU);
      cnt_d    = cnt_d + WuC;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(RU);
      cnt_d    = cnt_d - RuC;
    end
  end

  // Pointers advance in whole words, so each word occupies aligned contiguous units.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(RU); i++) begin
      rd_word[i*N +: N] = mem_q[rd_ptr_q + AW'(i)];
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok && !Sync_Flush) begin
      for (int i = 0; i < int'(WU); i++) begin
        mem_q[wr_ptr_q + AW'(i)] <= bus_io.DIN[i*N +: N];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Sync_Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      flags_q  <= flags_of('0);
      ovr_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_of(cnt_d);
      ovr_q    <= bus_io.PUSH & full_q;
      udr_q    <= bus_io.POP & empty_q;
      // In FWFT mode this tracks the head so DOUT holds its last value once empty.
      if (Fwft ? !empty_q : pop_ok) begin
        dout_q <= rd_word;
      end
    end
  end

  assign bus_io.DOUT            = (Fwft && !empty_q) ? rd_word : dout_q;
  assign bus_io.Full            = flags_q[5];
  assign bus_io.Almost_Full     = flags_q[4];
  assign bus_io.Full_Watermark  = flags_q[3];
  assign bus_io.Empty           = flags_q[2];
  assign bus_io.Almost_Empty    = flags_q[1];
  assign bus_io.Empty_Watermark = flags_q[0];
  assign bus_io.Overrun_Error   = ovr_q;
  assign bus_io.Underrun_Error  = udr_q;

endmodule

// File: tb/tb_sfifo_asym_gen.sv
// Directed bench for sfifo_asym_gen: 9->36, 36->9 and 18/18 FWFT instances,
// with a narrow-unit queue model and expected-word queues as scoreboard.
module tb_sfifo_asym_gen;

  logic clk = 1'b0;
  logic flush;
  always #5 clk = ~clk;

  sfifo_asym_gen_if #(.WR_DATA_WIDTH(9),  .RD_DATA_WIDTH(36)) ifa ();
  sfifo_asym_gen_if #(.WR_DATA_WIDTH(36), .RD_DATA_WIDTH(9))  ifb ();
  sfifo_asym_gen_if #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(18)) ifc ();

  sfifo_asym_gen #(
    .WR_DATA_WIDTH(9), .RD_DATA_WIDTH(36), .DEPTH_UNITS(4096),
    .UPAE_DBITS(12'd10), .UPAF_DBITS(12'd10), .FWFT(0)
  ) dut_a (.CLK(clk), .Sync_Flush(flush), .bus_io(ifa));

  sfifo_asym_gen #(
    .WR_DATA_WIDTH(36), .RD_DATA_WIDTH(9), .DEPTH_UNITS(4096),
    .UPAE_DBITS(12'd10), .UPAF_DBITS(12'd10), .FWFT(0)
  ) dut_b (.CLK(clk), .Sync_Flush(flush), .bus_io(ifb));

  sfifo_asym_gen #(
    .WR_DATA_WIDTH(18), .RD_DATA_WIDTH(18), .DEPTH_UNITS(32),
    .UPAE_DBITS(12'd10), .UPAF_DBITS(12'd10), .FWFT(1)
  ) dut_c (.CLK(clk), .Sync_Flush(flush), .bus_io(ifc));

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0]  ua[$];
  logic [35:0] ea[$];
  logic [8:0]  ub[$];
  logic [8:0]  eb[$];
  logic [17:0] uc[$];
  logic [35:0] w;
  logic [8:0]  last_b;
  logic [17:0] last_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_a_word();
    for (int i = 0; i < 4; i++) w[i*9 +: 9] = ua.pop_front();
    ea.push_back(w);
  endtask

  initial begin
    ifa.PUSH = 0; ifa.POP = 0; ifa.DIN = '0;
    ifb.PUSH = 0; ifb.POP = 0; ifb.DIN = '0;
    ifc.PUSH = 0; ifc.POP = 0; ifc.DIN = '0;
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;

    // Reset state
    chk("rst_a_empty", ifa.Empty, 1);
    chk("rst_a_full", ifa.Full, 0);
    chk("rst_a_ewm", ifa.Empty_Watermark, 1);
    chk("rst_a_fwm", ifa.Full_Watermark, 0);
    chk("rst_a_dout", ifa.DOUT, 0);
    chk("rst_c_afull", ifc.Almost_Full, 0);
    chk("rst_c_aempty", ifc.Almost_Empty, 0);

    // 9 -> 36 packing; partial words stay invisible
    for (int k = 1; k <= 4; k++) begin
      ifa.DIN = 9'(k);
      ifa.PUSH = 1;
      ua.push_back(9'(k));
      tick();
      chk("a_empty_fill", ifa.Empty, ua.size() < 4);
    end
    ifa.PUSH = 0;
    ifa.POP = 1;
    build_a_word();
    tick();
    ifa.POP = 0;
    chk("a_dout_pack", ifa.DOUT, ea.pop_front());
    chk("a_empty_after_pop", ifa.Empty, 1);

    // 36 -> 9 unpacking and underrun
    ifb.DIN = 36'h0_200C_0401;
    ifb.PUSH = 1;
    for (int i = 0; i < 4; i++) ub.push_back(ifb.DIN[i*9 +: 9]);
    tick();
    ifb.PUSH = 0;
    chk("b_empty_after_push", ifb.Empty, 0);
    for (int k = 0; k < 4; k++) begin
      ifb.POP = 1;
      eb.push_back(ub.pop_front());
      tick();
      last_b = eb.pop_front();
      chk("b_dout_unpack", ifb.DOUT, last_b);
    end
    chk("b_last_unit", ifb.DOUT, 9'h004);
    tick();
    chk("b_underrun", ifb.Underrun_Error, 1);
    chk("b_dout_hold", ifb.DOUT, last_b);
    ifb.POP = 0;
    tick();
    chk("b_underrun_pulse", ifb.Underrun_Error, 0);

    // 9 -> 36 fill to Full, overrun, then one pop
    for (int k = 0; k < 4096; k++) begin
      ifa.DIN = 9'(k);
      ifa.PUSH = 1;
      ua.push_back(9'(k));
      tick();
      if (k == 4094) begin
        chk("a_afull_4095", ifa.Almost_Full, 1);
        chk("a_notfull_4095", ifa.Full, 0);
      end
    end
    chk("a_full_4096", ifa.Full, 1);
    chk("a_afull_4096", ifa.Almost_Full, 0);
    chk("a_fwm_full", ifa.Full_Watermark, 1);
    ifa.DIN = 9'h1FF;
    tick();
    chk("a_overrun", ifa.Overrun_Error, 1);
    chk("a_full_kept", ifa.Full, 1);
    chk("a_afull_kept", ifa.Almost_Full, 0);
    ifa.PUSH = 0;
    ifa.POP = 1;
    build_a_word();
    tick();
    ifa.POP = 0;
    chk("a_overrun_pulse", ifa.Overrun_Error, 0);
    chk("a_full_after_pop", ifa.Full, 0);
    chk("a_dout_after_fill", ifa.DOUT, ea.pop_front());

    // Flush with PUSH asserted after 100 writes
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ua.delete();
    for (int k = 0; k < 100; k++) begin
      ifa.DIN = 9'(k + 7);
      ifa.PUSH = 1;
      ua.push_back(9'(k + 7));
      tick();
    end
    chk("a_empty_100", ifa.Empty, 0);
    flush = 1'b1;
    ifa.DIN = 9'h0AA;
    tick();
    flush = 1'b0;
    ifa.PUSH = 0;
    ua.delete();
    chk("fl_empty", ifa.Empty, 1);
    chk("fl_ewm", ifa.Empty_Watermark, 1);
    chk("fl_dout", ifa.DOUT, 0);
    chk("fl_full", ifa.Full, 0);
    ifa.POP = 1;
    tick();
    ifa.POP = 0;
    chk("fl_underrun", ifa.Underrun_Error, 1);
    chk("fl_dout_after_pop", ifa.DOUT, 0);

    // FWFT 18/18: head visible before POP, watermark boundaries
    ifc.DIN = 18'h3_A5A5;
    ifc.PUSH = 1;
    uc.push_back(18'h3_A5A5);
    tick();
    ifc.PUSH = 0;
    chk("c_empty_first", ifc.Empty, 0);
    chk("c_fwft_head", ifc.DOUT, uc[0]);
    tick();
    chk("c_fwft_hold", ifc.DOUT, 18'h3_A5A5);
    for (int k = 1; k < 32; k++) begin
      ifc.DIN = 18'(k * 37 + 5);
      ifc.PUSH = 1;
      uc.push_back(18'(k * 37 + 5));
      tick();
      chk("c_ewm", ifc.Empty_Watermark, uc.size() <= 10);
      chk("c_fwm", ifc.Full_Watermark, (32 - uc.size()) <= 10);
      chk("c_full", ifc.Full, uc.size() == 32);
      chk("c_head", ifc.DOUT, uc[0]);
    end

    // Simultaneous PUSH+POP at Full: pop wins, push overruns
    ifc.DIN = 18'h155;
    ifc.POP = 1;
    void'(uc.pop_front());
    tick();
    ifc.PUSH = 0;
    ifc.POP = 0;
    chk("c_both_overrun", ifc.Overrun_Error, 1);
    chk("c_both_full", ifc.Full, 0);
    chk("c_both_afull", ifc.Almost_Full, 1);
    chk("c_both_head", ifc.DOUT, uc[0]);

    // Drain
    for (int k = 0; k < 31; k++) begin
      ifc.POP = 1;
      last_c = uc.pop_front();
      tick();
      if (uc.size() > 0) chk("c_drain_head", ifc.DOUT, uc[0]);
      else chk("c_drain_empty", ifc.Empty, 1);
    end
    ifc.POP = 0;
    tick();
    chk("c_empty_hold", ifc.DOUT, last_c);
    chk("c_aempty_end", ifc.Almost_Empty, 0);
    chk("c_underrun_none", ifc.Underrun_Error, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
